// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//   Parameterised UART transmitter with a small transmit FIFO.
//   Frame: start (0), DATA_BITS data bits LSB first, optional parity bit,
//   STOP_BITS stop bits (1). Every bit lasts exactly BPS_CNT sys_clk cycles.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> one parity bit after the data bits (even, or odd when
//                  PARITY_ODD=1)
//     undefined -> no parity state, no parity logic, PARITY_ODD ignored
//
// Parameters
//   BPS_CNT    sys_clk cycles per bit, 2..65535
//   DATA_BITS  data bits per frame, 5..8
//   STOP_BITS  stop bits per frame, 1 or 2
//   FIFO_DEPTH FIFO entries, power of two, 2..16
//   PARITY_ODD 0 = even, 1 = odd (parity build only)
//
// Ports
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   tx_valid    in   write request
//   tx_data     in   word to send, LSB first
//   tx_ready    out  FIFO can accept a write (= !full)
//   tx_busy     out  FIFO non-empty or a frame in progress
//   fifo_level  out  FIFO occupancy
//   uart_txd    out  serial line, registered, idle high
//   dbg_state   out  current FSM state encoding
//
// Handshake: a write is taken on a rising edge where tx_valid && tx_ready.
// tx_ready is derived only from FIFO occupancy, never from tx_valid; while
// tx_ready is low, tx_valid is ignored and nothing in the FIFO changes.
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int unsigned BPS_CNT    = 434,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          uart_txd,
  output logic [2:0]                    dbg_state
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned IW = 3;

  // Elaboration-time guard against illegal parameter combinations.
  generate
    if (BPS_CNT < 2 || BPS_CNT > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
        !(STOP_BITS == 1 || STOP_BITS == 2) || FIFO_DEPTH < 2 ||
        FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PARITY_ODD > 1) begin : g_bad_params
      $error("uart_tx_param: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_head;

  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = tx_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr];

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;  // idle, or push and pop together
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_baud_cnt;
  logic [15:0]          w_cnt_nxt;
  logic [IW-1:0]        r_bit_idx;
  logic [IW-1:0]        w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_txd;
  logic                 w_txd_nxt;
  logic                 w_bit_end;

  assign w_bit_end = (r_baud_cnt == 16'(BPS_CNT - 1));

`ifdef UART_TX_PARITY_EN
  // Parity is captured together with the word so later FIFO writes cannot
  // affect the frame on the line.
  logic r_parity;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= (^w_head) ^ (PARITY_ODD != 0);
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_cnt_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  // uart_txd is registered, so the line value for the next state is chosen
  // here and loaded on the same edge as the state change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? 16'd0 : r_baud_cnt + 16'd1;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = 16'd0;
        w_txd_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
          w_txd_nxt   = 1'b0;
        end
      end

      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_idx_nxt   = '0;
          w_txd_nxt   = r_shift[0];
        end
      end

      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
            w_txd_nxt   = r_parity;
`else
            w_state_nxt = STOP;
            w_idx_nxt   = '0;
            w_txd_nxt   = 1'b1;
`endif
          end else begin
            w_idx_nxt   = r_bit_idx + IW'(1);
            w_shift_nxt = r_shift >> 1;
            w_txd_nxt   = r_shift[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_idx_nxt   = '0;
          w_txd_nxt   = 1'b1;
        end
      end
`endif

      STOP: begin
        // r_bit_idx counts stop bits so each is a full BPS_CNT long.
        if (w_bit_end) begin
          if (r_bit_idx == IW'(STOP_BITS - 1)) begin
            if (!w_empty) begin
              // Back-to-back: next start bit follows with no idle gap.
              w_pop       = 1'b1;
              w_shift_nxt = w_head;
              w_state_nxt = START;
              w_txd_nxt   = 1'b0;
            end else begin
              w_state_nxt = IDLE;
              w_txd_nxt   = 1'b1;
            end
          end else begin
            w_idx_nxt = r_bit_idx + IW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 16'd0;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  assign tx_ready   = !w_full;
  assign tx_busy    = (r_state != IDLE) || !w_empty;
  assign fifo_level = r_level;
  assign uart_txd   = r_txd;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_tx_param.sv
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int BPS = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME0 = (1 + 8 + PB + 1) * BPS;  // 8N1 lane
  localparam int FRAME1 = (1 + 5 + PB + 2) * BPS;  // 5-bit, 2 stop lane

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Lane 0: defaults (8 data, 1 stop, depth 4, even parity)
  logic       tx_valid0 = 1'b0;
  logic [7:0] tx_data0  = '0;
  logic       tx_ready0, tx_busy0, uart_txd0;
  logic [2:0] fifo_level0;
  logic [2:0] dbg_state0;

  // Lane 1: 5 data, 2 stop, odd parity
  logic       tx_valid1 = 1'b0;
  logic [4:0] tx_data1  = '0;
  logic       tx_ready1, tx_busy1, uart_txd1;
  logic [2:0] fifo_level1;
  logic [2:0] dbg_state1;

  logic [1:0] txd_vec;
  logic [1:0] busy_vec;
  assign txd_vec  = {uart_txd1, uart_txd0};
  assign busy_vec = {tx_busy1, tx_busy0};

  uart_tx_param #(.BPS_CNT(BPS)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .tx_valid(tx_valid0), .tx_data(tx_data0),
    .tx_ready(tx_ready0), .tx_busy(tx_busy0),
    .fifo_level(fifo_level0), .uart_txd(uart_txd0),
    .dbg_state(dbg_state0)
  );

  uart_tx_param #(.BPS_CNT(BPS), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .tx_valid(tx_valid1), .tx_data(tx_data1),
    .tx_ready(tx_ready1), .tx_busy(tx_busy1),
    .fifo_level(fifo_level1), .uart_txd(uart_txd1),
    .dbg_state(dbg_state1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         st_q0[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: decodes every frame on one lane, sampling each cycle on the
  // falling edge, and compares against the head of that lane's queue.
  task automatic mon_lane(input int sel, input int dbits, input int sbits, input logic odd);
    int         nb;
    logic [11:0] bits;
    logic       shape_ok, aborted, v, first, stop_ok;
    logic [7:0] got, exp_d;
    nb = 1 + dbits + PB + sbits;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && txd_vec[sel] == 1'b0) begin
        if (sel == 0) st_q0.push_back(cyc);
        bits = '0; shape_ok = 1'b1; aborted = 1'b0; first = 1'b0;
        for (int b = 0; b < nb; b++) begin
          for (int c = 0; c < BPS; c++) begin
            if (b != 0 || c != 0) @(negedge sys_clk);
            if (!sys_rst_n) aborted = 1'b1;
            v = txd_vec[sel];
            if (c == 0) first = v;
            else if (v != first) shape_ok = 1'b0;
          end
          bits[b] = first;
          if (aborted) break;
        end
        if (aborted) begin
          wait (sys_rst_n);
        end else begin
          got = '0;
          for (int i = 0; i < dbits; i++) got[i] = bits[1 + i];
          stop_ok = 1'b1;
          for (int s = 0; s < sbits; s++) stop_ok &= bits[1 + dbits + PB + s];
          chk($sformatf("lane%0d_start_bit", sel), bits[0], 0);
          chk($sformatf("lane%0d_bit_width", sel), shape_ok, 1);
          chk($sformatf("lane%0d_stop_bits", sel), stop_ok, 1);
          if ((sel == 0 && exp_q0.size() == 0) || (sel == 1 && exp_q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL lane%0d_unexpected_frame: got 0x%0h expected no frame", sel, got);
          end else begin
            exp_d = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("lane%0d_data", sel), got, exp_d);
`ifdef UART_TX_PARITY_EN
            chk($sformatf("lane%0d_parity", sel), bits[1 + dbits], (^exp_d) ^ odd);
`endif
          end
        end
      end
    end
  endtask

  initial mon_lane(0, 8, 1, 1'b0);
  initial mon_lane(1, 5, 2, 1'b1);

  // ---------------------------------------------------------------------------
  // Driver tasks (called on a falling edge, return on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send0(input logic [7:0] d);
    int n = 0;
    tx_valid0 = 1'b1; tx_data0 = d;
    while (!tx_ready0 && n < 1000) begin @(negedge sys_clk); n++; end
    if (!tx_ready0) begin
      chk("lane0_send_timeout", tx_ready0, 1);
      tx_valid0 = 1'b0;
    end else begin
      exp_q0.push_back(d);
      @(negedge sys_clk);
      tx_valid0 = 1'b0;
    end
  endtask

  task automatic send1(input logic [4:0] d);
    int n = 0;
    tx_valid1 = 1'b1; tx_data1 = d;
    while (!tx_ready1 && n < 1000) begin @(negedge sys_clk); n++; end
    if (!tx_ready1) begin
      chk("lane1_send_timeout", tx_ready1, 1);
      tx_valid1 = 1'b0;
    end else begin
      exp_q1.push_back({3'b000, d});
      @(negedge sys_clk);
      tx_valid1 = 1'b0;
    end
  endtask

  // Counts rising edges until tx_busy drops; t1 is the line after the first edge.
  task automatic meas_idle(input int sel, input int budget, output int n, output logic t1);
    n = 0; t1 = 1'b1;
    do begin
      @(posedge sys_clk); #1;
      n++;
      if (n == 1) t1 = txd_vec[sel];
    end while (busy_vec[sel] && n < budget);
    chk($sformatf("lane%0d_idle_reached", sel), busy_vec[sel], 0);
    @(negedge sys_clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int   n, c1, cb, tgt, low_cnt;
    logic t1;

    #1 sys_rst_n = 1'b0;
    #3;
    chk("rst_txd0", uart_txd0, 1);
    chk("rst_busy0", tx_busy0, 0);
    chk("rst_ready0", tx_ready0, 1);
    chk("rst_level0", fifo_level0, 0);
    chk("rst_state0", dbg_state0, 0);
    chk("rst_txd1", uart_txd1, 1);
    chk("rst_level1", fifo_level1, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single 8'h55 on the 8N1 lane: start-bit low from the edge after the write.
    send0(8'h55);
    chk("w55_level_after_write", fifo_level0, 1);
    chk("w55_txd_at_k", uart_txd0, 1);
    chk("w55_busy_at_k", tx_busy0, 1);
    meas_idle(0, 500, n, t1);
    chk("w55_start_at_k1", t1, 0);
    chk("w55_busy_edges", n, FRAME0 + 1);

    // 8'h07: parity-bearing pattern when the parity build is used.
    send0(8'h07);
    meas_idle(0, 500, n, t1);
    chk("w07_busy_edges", n, FRAME0 + 1);

    // 5-bit lane, two stop bits.
    send1(5'h1F);
    meas_idle(1, 500, n, t1);
    chk("w1f_start_at_k1", t1, 0);
    chk("w1f_busy_edges", n, FRAME1 + 1);
    send1(5'h0A);
    meas_idle(1, 500, n, t1);
    chk("w0a_busy_edges", n, FRAME1 + 1);

    // Burst of five with tx_valid held: fill the FIFO, then push+pop together.
    st_q0.delete();
    send0(8'hA0);
    send0(8'hA1);
    c1 = cyc;
    send0(8'hA2);
    send0(8'hA3);
    send0(8'hA4);
    chk("burst_ready_full", tx_ready0, 0);
    chk("burst_level_full", fifo_level0, 4);
    tx_valid0 = 1'b1; tx_data0 = 8'hEE;  // must be ignored while full
    repeat (3) begin
      @(posedge sys_clk); #1;
      chk("full_write_ignored", fifo_level0, 4);
    end
    @(negedge sys_clk);
    tx_valid0 = 1'b0;
    tgt = c1 + 2 * FRAME0 - 1;
    n = 0;
    while (cyc != tgt && n < 1000) begin @(negedge sys_clk); n++; end
    chk("pushpop_level_before", fifo_level0, 3);
    send0(8'hA5);
    chk("pushpop_level_after", fifo_level0, 3);
    chk("pushpop_state_start", dbg_state0, 1);
    meas_idle(0, 1000, n, t1);
    chk("burst_frame_count", st_q0.size(), 6);
    for (int i = 1; i < st_q0.size(); i++)
      chk("burst_no_gap", st_q0[i] - st_q0[i-1], FRAME0);

    // Reset during the data bits of the second of three queued bytes.
    send0(8'h3C);
    send0(8'hC3);
    cb = cyc;
    send0(8'h81);
    tgt = cb + FRAME0 + 10;
    n = 0;
    while (cyc != tgt && n < 1000) begin @(negedge sys_clk); n++; end
    chk("midreset_in_data", dbg_state0, 2);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midreset_txd", uart_txd0, 1);
    chk("midreset_level", fifo_level0, 0);
    chk("midreset_busy", tx_busy0, 0);
    chk("midreset_ready", tx_ready0, 1);
    exp_q0.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    low_cnt = 0;
    repeat (150) begin
      @(negedge sys_clk);
      if (uart_txd0 !== 1'b1 || tx_busy0 !== 1'b0) low_cnt++;
    end
    chk("post_reset_quiet", low_cnt, 0);
    chk("post_reset_level", fifo_level0, 0);

    chk("exp_q0_drained", exp_q0.size(), 0);
    chk("exp_q1_drained", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
